// File: rtl/gpio_pad_pkg.sv
// Shared types and constants for the GPIO pad controller.
// Interrupt modes are encoded two bits per channel on the register interface.
package gpio_pad_pkg;

    typedef enum logic [1:0] {
        IRQ_RISE  = 2'b00,
        IRQ_FALL  = 2'b01,
        IRQ_BOTH  = 2'b10,
        IRQ_LEVEL = 2'b11
    } irq_mode_e;

    localparam int SYNC_STAGE_MIN = 2;

endpackage

// File: rtl/gpio_in_filter.sv
// One GPIO input channel: metastability synchroniser, debounce filter and
// edge/level event detection on the filtered value.
module gpio_in_filter
    import gpio_pad_pkg::*;
#(
    parameter int SYNC_STAGE = 2,
    parameter int DB_WIDTH   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pad_c_i,
    input  logic [DB_WIDTH-1:0] db_max_i,
    input  irq_mode_e           mode_i,
    output logic                in_o,
    output logic                event_o
);

    // A chain shorter than two flops gives no metastability protection.
    localparam int STAGES = (SYNC_STAGE < SYNC_STAGE_MIN) ? SYNC_STAGE_MIN : SYNC_STAGE;

    logic [STAGES-1:0]   sync_reg;
    logic [DB_WIDTH-1:0] cnt_reg;
    logic                in_reg;
    logic                prev_reg;
    logic                sync_bit;
    logic [DB_WIDTH:0]   cnt_inc;

    assign sync_bit = sync_reg[STAGES-1];
    assign cnt_inc  = {1'b0, cnt_reg} + {{DB_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], pad_c_i};
        end
    end

    // Counter only advances while the synchronised value disagrees with the
    // stable one, so any shorter glitch drops it back to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg  <= '0;
            in_reg   <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= in_reg;
            if (db_max_i == '0) begin
                in_reg  <= sync_bit;
                cnt_reg <= '0;
            end else if (sync_bit == in_reg) begin
                cnt_reg <= '0;
            end else if (cnt_inc < {1'b0, db_max_i}) begin
                cnt_reg <= cnt_inc[DB_WIDTH-1:0];
            end else begin
                in_reg  <= sync_bit;
                cnt_reg <= '0;
            end
        end
    end

    always_comb begin
        event_o = 1'b0;
        unique case (mode_i)
            IRQ_RISE:  event_o = in_reg & ~prev_reg;
            IRQ_FALL:  event_o = ~in_reg & prev_reg;
            IRQ_BOTH:  event_o = in_reg ^ prev_reg;
            IRQ_LEVEL: event_o = in_reg;
            default:   event_o = 1'b0;
        endcase
    end

    assign in_o = in_reg;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Multi-channel GPIO front end: registered pad controls, filtered pad inputs
// and sticky per-channel interrupt status with a registered summary IRQ.
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int CH_NUM     = 8,
    parameter int SYNC_STAGE = 2,
    parameter int DB_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CH_NUM-1:0]     dir_i,
    input  logic [CH_NUM-1:0]     out_i,
    input  logic [CH_NUM-1:0]     pull_en_i,
    input  logic [DB_WIDTH-1:0]   db_max_i,
    input  logic [CH_NUM-1:0]     irq_en_i,
    input  logic [2*CH_NUM-1:0]   irq_mode_i,
    input  logic [CH_NUM-1:0]     irq_clr_i,
    output logic [CH_NUM-1:0]     pad_i_o,
    output logic [CH_NUM-1:0]     pad_oen_o,
    output logic [CH_NUM-1:0]     pad_ren_o,
    input  logic [CH_NUM-1:0]     pad_c_i,
    output logic [CH_NUM-1:0]     in_o,
    output logic [CH_NUM-1:0]     irq_stat_o,
    output logic                  irq_o
);

    logic [CH_NUM-1:0] pad_i_reg;
    logic [CH_NUM-1:0] pad_oen_reg;
    logic [CH_NUM-1:0] pad_ren_reg;
    logic [CH_NUM-1:0] irq_stat_reg;
    logic [CH_NUM-1:0] event_vec;
    logic              irq_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pad_i_reg   <= '0;
            pad_oen_reg <= '1;
            pad_ren_reg <= '1;
        end else begin
            pad_i_reg   <= out_i;
            pad_oen_reg <= ~dir_i;
            pad_ren_reg <= ~pull_en_i;
        end
    end

    // Output channels are filtered too, which gives readback of the driven level.
    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            gpio_in_filter #(
                .SYNC_STAGE (SYNC_STAGE),
                .DB_WIDTH   (DB_WIDTH)
            ) u_filter (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .pad_c_i  (pad_c_i[gi]),
                .db_max_i (db_max_i),
                .mode_i   (irq_mode_e'(irq_mode_i[2*gi +: 2])),
                .in_o     (in_o[gi]),
                .event_o  (event_vec[gi])
            );
        end
    endgenerate

    // Set is applied after clear so an event coinciding with a clear is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_stat_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            irq_stat_reg <= (irq_stat_reg & ~irq_clr_i) | (irq_en_i & event_vec);
            irq_reg      <= |irq_stat_reg;
        end
    end

    assign pad_i_o    = pad_i_reg;
    assign pad_oen_o  = pad_oen_reg;
    assign pad_ren_o  = pad_ren_reg;
    assign irq_stat_o = irq_stat_reg;
    assign irq_o      = irq_reg;

endmodule
